// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDU_Ctr opcodes, default latencies, start decode.
// Define MDU_MADD_EN to enable the madd/maddu/msub accumulate opcodes.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;
    localparam logic [3:0] MDU_MADD  = 4'd9;
    localparam logic [3:0] MDU_MADDU = 4'd10;
    localparam logic [3:0] MDU_MSUB  = 4'd11;

    localparam int MDU_MUL_CYCLES = 5;
    localparam int MDU_DIV_CYCLES = 10;
    localparam int MDU_CNT_W      = 8;

    // True for opcodes that occupy the unit for several cycles.
    function automatic logic is_mdu_start_op(input logic [3:0] ctr);
        logic hit;
        hit = 1'b0;
        case (ctr)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: hit = 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB:          hit = 1'b1;
`endif
            default:                                hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/mdu_counter.sv
// Countdown for in-flight MDU operations: load sets busy, busy drops after load_val cycles.
// done is a one-cycle pulse in the last busy cycle, marking the write-back edge.
module mdu_counter
    import mdu_pkg::*;
#(
    parameter int W = MDU_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         busy,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (load && !busy) begin
            cnt  <= load_val;
            busy <= 1'b1;
        end else if (busy) begin
            cnt <= cnt - W'(1);
            if (cnt == W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign done = busy && (cnt == W'(1));

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit owning HI/LO; serves mult/multu/div/divu and mfhi/mflo/mthi/mtlo.
// Define MDU_MADD_EN to add madd/maddu/msub (accumulate into HI/LO).
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MDU_MUL_CYCLES,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDU_Ctr,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_Out
);

    // Handshake with the stall unit: Start is asserted only when Busy is low and
    // the opcode is a multi-cycle one; the operation is accepted on that same edge.
    // While Busy is high every new opcode is ignored; the stall unit holds it in D.
    assign Start = is_mdu_start_op(MDU_Ctr) && !Busy;

    logic is_div;
    logic sgn_mul;
    logic sgn_div;
    assign is_div  = (MDU_Ctr == MDU_DIV) || (MDU_Ctr == MDU_DIVU);
    assign sgn_div = (MDU_Ctr == MDU_DIV);
`ifdef MDU_MADD_EN
    assign sgn_mul = (MDU_Ctr == MDU_MULT) || (MDU_Ctr == MDU_MADD) || (MDU_Ctr == MDU_MSUB);
`else
    assign sgn_mul = (MDU_Ctr == MDU_MULT);
`endif

    // One 64x64 multiplier serves signed and unsigned: the low 64 bits of the
    // product of the sign- or zero-extended operands are the correct result.
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    assign ext_a   = {{32{sgn_mul & A[31]}}, A};
    assign ext_b   = {{32{sgn_mul & B[31]}}, B};
    assign product = ext_a * ext_b;

    // Signed division is done on magnitudes, so INT_MIN / -1 wraps to INT_MIN cleanly.
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    assign a_neg   = sgn_div & A[31];
    assign b_neg   = sgn_div & B[31];
    assign mag_a   = a_neg ? -A : A;
    assign mag_b   = b_neg ? -B : B;
    assign divisor = (B == 32'd0) ? 32'd1 : mag_b;
    assign q_mag   = mag_a / divisor;
    assign r_mag   = mag_a % divisor;
    assign quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem     = a_neg ? -r_mag : r_mag;

    logic [63:0] result;
    always_comb begin
        result = product;
        case (MDU_Ctr)
            MDU_DIV, MDU_DIVU:   result = {rem, quot};
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU: result = {HI, LO} + product;
            MDU_MSUB:            result = {HI, LO} - product;
`endif
            default:             result = product;
        endcase
    end

    logic [MDU_CNT_W-1:0] cnt_load;
    logic                 done;
    assign cnt_load = is_div ? MDU_CNT_W'(DIV_CYCLES) : MDU_CNT_W'(MUL_CYCLES);

    mdu_counter #(.W(MDU_CNT_W)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (Start),
        .load_val (cnt_load),
        .busy     (Busy),
        .done     (done)
    );

    // Pending result is captured at the Start edge and committed on done;
    // a divide by zero commits nothing.
    logic [31:0] hi_n;
    logic [31:0] lo_n;
    logic        pend_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_n    <= 32'd0;
            lo_n    <= 32'd0;
            pend_wr <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else begin
            if (Start) begin
                hi_n    <= result[63:32];
                lo_n    <= result[31:0];
                pend_wr <= !(is_div && (B == 32'd0));
            end
            if (done) begin
                if (pend_wr) begin
                    HI <= hi_n;
                    LO <= lo_n;
                end
            end else if (!Busy) begin
                if (MDU_Ctr == MDU_MTHI) HI <= A;
                if (MDU_Ctr == MDU_MTLO) LO <= A;
            end
        end
    end

    always_comb begin
        MDU_Out = 32'd0;
        if (MDU_Ctr == MDU_MFHI) MDU_Out = HI;
        else if (MDU_Ctr == MDU_MFLO) MDU_Out = LO;
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases, busy/ignore, async reset, randomized ops
// checked against a plain-arithmetic HI/LO model.
module tb_mdu_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk;
    logic        reset;
    logic [3:0]  MDU_Ctr;
    logic [31:0] A;
    logic [31:0] B;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_Out;

    int checks;
    int errors;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset   (reset),
        .MDU_Ctr (MDU_Ctr),
        .A       (A),
        .B       (B),
        .Start   (Start),
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO),
        .MDU_Out (MDU_Out)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // mthi/mtlo must never be presented while an operation is in flight
    always @(negedge clk) begin
        if (!reset) begin
            assert (!(Busy && (MDU_Ctr == 4'd7 || MDU_Ctr == 4'd8)))
                else $error("mthi/mtlo issued while Busy");
        end
    end

    // reference model: number of Busy cycles an opcode causes (0 = single cycle)
    function automatic int op_cycles(input logic [3:0] op);
        case (op)
            4'd1, 4'd2: return MUL_N;
            4'd3, 4'd4: return DIV_N;
`ifdef MDU_MADD_EN
            4'd9, 4'd10, 4'd11: return MUL_N;
`endif
            default: return 0;
        endcase
    endfunction

    // reference model: HI/LO after the opcode has fully taken effect
    function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] hi_in, input logic [31:0] lo_in,
                                   output logic [31:0] hi_out, output logic [31:0] lo_out);
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] p;
        logic [63:0] v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi_out = hi_in;
        lo_out = lo_in;
        case (op)
            4'd1: begin p = 64'(sa * sb); {hi_out, lo_out} = p; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; {hi_out, lo_out} = p; end
            4'd3: if (b != 32'd0) begin
                sq = sa / sb;
                sr = sa % sb;
                v = 64'(sq); lo_out = v[31:0];
                v = 64'(sr); hi_out = v[31:0];
            end
            4'd4: if (b != 32'd0) begin
                lo_out = a / b;
                hi_out = a % b;
            end
            4'd7: hi_out = a;
            4'd8: lo_out = a;
`ifdef MDU_MADD_EN
            4'd9:  begin p = {hi_in, lo_in} + 64'(sa * sb); {hi_out, lo_out} = p; end
            4'd10: begin p = {hi_in, lo_in} + {32'd0, a} * {32'd0, b}; {hi_out, lo_out} = p; end
            4'd11: begin p = {hi_in, lo_in} - 64'(sa * sb); {hi_out, lo_out} = p; end
`endif
            default: ;
        endcase
    endfunction

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        MDU_Ctr = op;
        A = a;
        B = b;
    endtask

    task automatic test_reset();
        drive(4'd0, 32'd0, 32'd0);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", LO); end
        checks++; if (Start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", Start); end
        checks++; if (MDU_Out !== 32'd0) begin errors++; $display("FAIL reset_out: got %h want 00000000", MDU_Out); end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [3:0]  d_op [7];
        logic [31:0] d_a  [7];
        logic [31:0] d_b  [7];
        logic [31:0] d_hi [7];
        logic [31:0] d_lo [7];
        int          d_n  [7];
        d_op[0] = 4'd1; d_a[0] = 32'hFFFFFFFE; d_b[0] = 32'd3; d_hi[0] = 32'hFFFFFFFF; d_lo[0] = 32'hFFFFFFFA; d_n[0] = 5;
        d_op[1] = 4'd2; d_a[1] = 32'hFFFFFFFF; d_b[1] = 32'd2; d_hi[1] = 32'h00000001; d_lo[1] = 32'hFFFFFFFE; d_n[1] = 5;
        d_op[2] = 4'd3; d_a[2] = 32'hFFFFFFF9; d_b[2] = 32'd2; d_hi[2] = 32'hFFFFFFFF; d_lo[2] = 32'hFFFFFFFD; d_n[2] = 10;
        d_op[3] = 4'd4; d_a[3] = 32'hFFFFFFF9; d_b[3] = 32'd2; d_hi[3] = 32'h00000001; d_lo[3] = 32'h7FFFFFFC; d_n[3] = 10;
        d_op[4] = 4'd3; d_a[4] = 32'h80000000; d_b[4] = 32'hFFFFFFFF; d_hi[4] = 32'h00000000; d_lo[4] = 32'h80000000; d_n[4] = 10;
        d_op[5] = 4'd7; d_a[5] = 32'h12345678; d_b[5] = 32'd0; d_hi[5] = 32'h12345678; d_lo[5] = 32'h80000000; d_n[5] = 0;
        d_op[6] = 4'd4; d_a[6] = 32'h00000055; d_b[6] = 32'd0; d_hi[6] = 32'h12345678; d_lo[6] = 32'h80000000; d_n[6] = 10;
        for (int i = 0; i < 7; i++) begin
            drive(d_op[i], d_a[i], d_b[i]);
            #1;
            checks++;
            if (Start !== (d_n[i] != 0)) begin
                errors++; $display("FAIL dir_start[%0d]: got %b want %b", i, Start, d_n[i] != 0);
            end
            next_cycle();
            drive(4'd0, 32'd0, 32'd0);
            for (int k = 1; k <= d_n[i]; k++) begin
                #1;
                checks++;
                if (Busy !== 1'b1) begin errors++; $display("FAIL dir_busy[%0d] cycle t+%0d: got %b want 1", i, k, Busy); end
                next_cycle();
            end
            #1;
            checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL dir_idle[%0d]: got %b want 0", i, Busy); end
            checks++; if (HI !== d_hi[i]) begin errors++; $display("FAIL dir_hi[%0d]: got %h want %h", i, HI, d_hi[i]); end
            checks++; if (LO !== d_lo[i]) begin errors++; $display("FAIL dir_lo[%0d]: got %h want %h", i, LO, d_lo[i]); end
        end
    endtask

    task automatic test_back_to_back();
        drive(4'd1, 32'd3, 32'd4);
        #1;
        checks++; if (Start !== 1'b1) begin errors++; $display("FAIL b2b_start1: got %b want 1", Start); end
        next_cycle();
        drive(4'd1, 32'd5, 32'd6);
        #1;
        checks++; if (Start !== 1'b0) begin errors++; $display("FAIL b2b_start2: got %b want 0", Start); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", Busy); end
        next_cycle();
        drive(4'd0, 32'd0, 32'd0);
        repeat (4) next_cycle();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", Busy); end
        checks++; if ({HI, LO} !== 64'd12) begin errors++; $display("FAIL b2b_result: got %h want %h", {HI, LO}, 64'd12); end
        repeat (6) next_cycle();
        checks++; if ({HI, LO} !== 64'd12) begin errors++; $display("FAIL b2b_no_second: got %h want %h", {HI, LO}, 64'd12); end
        drive(4'd8, 32'h0000ABCD, 32'd0);
        next_cycle();
        drive(4'd6, 32'd0, 32'd0);
        #1;
        checks++; if (MDU_Out !== 32'h0000ABCD) begin errors++; $display("FAIL mflo_out: got %h want 0000abcd", MDU_Out); end
        drive(4'd5, 32'd0, 32'd0);
        #1;
        checks++; if (MDU_Out !== 32'd0) begin errors++; $display("FAIL mfhi_out: got %h want 00000000", MDU_Out); end
        drive(4'd0, 32'd0, 32'd0);
        #1;
        checks++; if (MDU_Out !== 32'd0) begin errors++; $display("FAIL none_out: got %h want 00000000", MDU_Out); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        drive(4'd1, 32'hFFFFFFFE, 32'd3);
        next_cycle();
        drive(4'd0, 32'd0, 32'd0);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", Busy); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL rmid_hi: got %h want 00000000", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL rmid_lo: got %h want 00000000", LO); end
        next_cycle();
        reset = 1'b0;
        for (int k = 5; k <= 7; k++) begin
            next_cycle();
            checks++;
            if ({Busy, HI, LO} !== 65'd0) begin
                errors++; $display("FAIL rmid_late t+%0d: busy %b hi %h lo %h want all zero", k, Busy, HI, LO);
            end
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        logic [31:0] eout;
        int          n;
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            n = op_cycles(op);
            ref_op(op, a, b, m_hi, m_lo, eh, el);
            eout = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
            drive(op, a, b);
            #1;
            checks++; if (Start !== (n != 0)) begin errors++; $display("FAIL rnd_start[%0d] op %0d: got %b want %b", i, op, Start, n != 0); end
            checks++; if (MDU_Out !== eout) begin errors++; $display("FAIL rnd_out[%0d] op %0d: got %h want %h", i, op, MDU_Out, eout); end
            next_cycle();
            for (int k = 1; k <= n; k++) begin
                c = 4'($urandom_range(0, 13));
                if (c >= 4'd7) c = c + 4'd2;
                drive(c, $urandom, $urandom);
                #1;
                checks++;
                if (Busy !== 1'b1 || Start !== 1'b0) begin
                    errors++; $display("FAIL rnd_busy[%0d] t+%0d: busy %b start %b want 1 0", i, k, Busy, Start);
                end
                checks++;
                if (HI !== m_hi || LO !== m_lo) begin
                    errors++; $display("FAIL rnd_hold[%0d] t+%0d: got %h_%h want %h_%h", i, k, HI, LO, m_hi, m_lo);
                end
                next_cycle();
            end
            drive(4'd0, 32'd0, 32'd0);
            #1;
            m_hi = eh;
            m_lo = el;
            checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rnd_idle[%0d]: got %b want 0", i, Busy); end
            checks++;
            if (HI !== m_hi || LO !== m_lo) begin
                errors++; $display("FAIL rnd_result[%0d] op %0d a %h b %h: got %h_%h want %h_%h", i, op, a, b, HI, LO, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
